control_sequencer: RTL

Hardwired Moore control unit for the single-bus Datapath. It decodes IR[31:27] and steps through T-states, driving the Datapath's register-select, bus-gate, ALU-op and RAM strobes one state per clock. It replaces hand-written testbench control sequences, so the Datapath runs fetch/execute autonomously. Its outputs connect 1:1 to the same-named Datapath inputs.

---
 rtl/control_sequencer_pkg.sv | 74 +++++++
 rtl/control_sequencer_op_decode.sv | 40 ++++
 rtl/control_sequencer.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the hardwired control sequencer: opcode values,
// T-state encoding, instruction classes and the ALU-select one-hot layout.
package ctrl_defs;

  // Opcode field values (IR[31:27])
  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // Sequencer states, 4-bit encoding
  typedef enum logic [3:0] {
    S_RESET = 4'd0,
    S_T0    = 4'd1,
    S_T1    = 4'd2,
    S_T2    = 4'd3,
    S_T3    = 4'd4,
    S_T4    = 4'd5,
    S_T5    = 4'd6,
    S_T6    = 4'd7,
    S_T7    = 4'd8,
    S_HALT  = 4'd9
  } state_t;

  // Instruction classes: each class shares one execute sequence
  typedef enum logic [3:0] {
    CLS_LOAD,
    CLS_LOADI,
    CLS_STORE,
    CLS_ALU_R,
    CLS_ALU_I,
    CLS_UNARY,
    CLS_NOP,
    CLS_HALT,
    CLS_ILLEGAL
  } iclass_t;

  // Bit positions of the ALU-select one-hot
  localparam int ALU_W  = 11;
  localparam int A_ADD  = 0;
  localparam int A_SUB  = 1;
  localparam int A_AND  = 2;
  localparam int A_OR   = 3;
  localparam int A_SHR  = 4;
  localparam int A_SHRA = 5;
  localparam int A_SHL  = 6;
  localparam int A_ROR  = 7;
  localparam int A_ROL  = 8;
  localparam int A_NEG  = 9;
  localparam int A_NOT  = 10;

  typedef logic [ALU_W-1:0] alu_onehot_t;

  // One-hot ALU select with only bit idx set
  function automatic alu_onehot_t alu_bit(input int idx);
    return alu_onehot_t'(1) << idx;
  endfunction

endpackage

// File: rtl/control_sequencer_op_decode.sv
// Opcode decoder: maps the 5-bit opcode to its instruction class and the
// ALU operation used during execute. Loads and stores select ADD, which
// forms the effective address.
module op_decode
  import ctrl_defs::*;
(
  input  logic [4:0]  i_opcode,
  output iclass_t     o_class,
  output alu_onehot_t o_alu
);

  // Purely combinational class/ALU-op lookup; unknown opcodes are ILLEGAL
  always_comb begin
    o_class = CLS_ILLEGAL;
    o_alu   = '0;
    case (i_opcode)
      OP_LD:   begin o_class = CLS_LOAD;  o_alu = alu_bit(A_ADD);  end
      OP_LDI:  begin o_class = CLS_LOADI; o_alu = alu_bit(A_ADD);  end
      OP_ST:   begin o_class = CLS_STORE; o_alu = alu_bit(A_ADD);  end
      OP_ADD:  begin o_class = CLS_ALU_R; o_alu = alu_bit(A_ADD);  end
      OP_SUB:  begin o_class = CLS_ALU_R; o_alu = alu_bit(A_SUB);  end
      OP_AND:  begin o_class = CLS_ALU_R; o_alu = alu_bit(A_AND);  end
      OP_OR:   begin o_class = CLS_ALU_R; o_alu = alu_bit(A_OR);   end
      OP_ROR:  begin o_class = CLS_ALU_R; o_alu = alu_bit(A_ROR);  end
      OP_ROL:  begin o_class = CLS_ALU_R; o_alu = alu_bit(A_ROL);  end
      OP_SHR:  begin o_class = CLS_ALU_R; o_alu = alu_bit(A_SHR);  end
      OP_SHRA: begin o_class = CLS_ALU_R; o_alu = alu_bit(A_SHRA); end
      OP_SHL:  begin o_class = CLS_ALU_R; o_alu = alu_bit(A_SHL);  end
      OP_ADDI: begin o_class = CLS_ALU_I; o_alu = alu_bit(A_ADD);  end
      OP_ANDI: begin o_class = CLS_ALU_I; o_alu = alu_bit(A_AND);  end
      OP_ORI:  begin o_class = CLS_ALU_I; o_alu = alu_bit(A_OR);   end
      OP_NEG:  begin o_class = CLS_UNARY; o_alu = alu_bit(A_NEG);  end
      OP_NOT:  begin o_class = CLS_UNARY; o_alu = alu_bit(A_NOT);  end
      OP_NOP:  o_class = CLS_NOP;
      OP_HALT: o_class = CLS_HALT;
      default: o_class = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit for the single-bus datapath. Steps through
// fetch (T0-T2) and a per-class execute sequence (T3-T7), one control word
// per clock. Define CTRL_MEM_WAIT_EN to add a mem_ready input that stretches
// the memory-access states (T1, ld-T6, st-T6) until memory responds.
module control_sequencer
  import ctrl_defs::*;
#(
  parameter int IR_W    = 32,
  parameter int OPC_MSB = 31
) (
  input  logic            clock,
  input  logic            clear,
`ifdef CTRL_MEM_WAIT_EN
  input  logic            mem_ready,
`endif
  input  logic [IR_W-1:0] IR,
  output logic            run,
  output logic            illegal,
  output logic            PCin,
  output logic            PCout,
  output logic            IncPC,
  output logic            MARin,
  output logic            MDRin,
  output logic            MDRout,
  output logic            MDMuxread,
  output logic            IRin,
  output logic            Yin,
  output logic            Zlowin,
  output logic            Zlowout,
  output logic            CSEout,
  output logic            Gra,
  output logic            Grb,
  output logic            Grc,
  output logic            Rin,
  output logic            Rout,
  output logic            BAout,
  output logic            RAMread,
  output logic            RAMwrite,
  output logic            ADD,
  output logic            SUB,
  output logic            AND,
  output logic            OR,
  output logic            SHR,
  output logic            SHRA,
  output logic            SHL,
  output logic            ROR,
  output logic            ROL,
  output logic            NEG,
  output logic            NOT,
  output logic            HIin,
  output logic            LOin,
  output logic            HIout,
  output logic            LOout,
  output logic            Zhighin,
  output logic            Zhighout,
  output logic            MUL,
  output logic            DIV,
  output logic            InPortout,
  output logic            OutPortin,
  output logic            CONin
);

  state_t      r_state;
  state_t      w_state_next;
  iclass_t     w_class;
  alu_onehot_t w_dec_alu;
  alu_onehot_t w_alu_sel;
  logic [4:0]  w_opcode;
  logic        w_mem_ready;
  logic        w_unused_ir;

  assign w_opcode    = IR[OPC_MSB -: 5];
  // Only the opcode field steers the sequencer; the rest belongs to the datapath
  assign w_unused_ir = ^IR;

`ifdef CTRL_MEM_WAIT_EN
  assign w_mem_ready = mem_ready;
`else
  assign w_mem_ready = 1'b1;
`endif

  op_decode u_op_decode (
    .i_opcode (w_opcode),
    .o_class  (w_class),
    .o_alu    (w_dec_alu)
  );

  assign {NOT, NEG, ROL, ROR, SHL, SHRA, SHR, OR, AND, SUB, ADD} = w_alu_sel;

  // Reserved datapath controls are never exercised by this instruction set
  assign HIin      = 1'b0;
  assign LOin      = 1'b0;
  assign HIout     = 1'b0;
  assign LOout     = 1'b0;
  assign Zhighin   = 1'b0;
  assign Zhighout  = 1'b0;
  assign MUL       = 1'b0;
  assign DIV       = 1'b0;
  assign InPortout = 1'b0;
  assign OutPortin = 1'b0;
  assign CONin     = 1'b0;

  // State register; clear wins over every transition, including memory waits
  always_ff @(posedge clock) begin
    if (clear) begin
      r_state <= S_RESET;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and Moore control-word decode from state and instruction class
  always_comb begin
    w_state_next = r_state;
    run       = 1'b0;
    illegal   = 1'b0;
    PCin      = 1'b0;
    PCout     = 1'b0;
    IncPC     = 1'b0;
    MARin     = 1'b0;
    MDRin     = 1'b0;
    MDRout    = 1'b0;
    MDMuxread = 1'b0;
    IRin      = 1'b0;
    Yin       = 1'b0;
    Zlowin    = 1'b0;
    Zlowout   = 1'b0;
    CSEout    = 1'b0;
    Gra       = 1'b0;
    Grb       = 1'b0;
    Grc       = 1'b0;
    Rin       = 1'b0;
    Rout      = 1'b0;
    BAout     = 1'b0;
    RAMread   = 1'b0;
    RAMwrite  = 1'b0;
    w_alu_sel = '0;
    case (r_state)
      S_RESET: w_state_next = S_T0;
      S_T0: begin
        run = 1'b1; PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zlowin = 1'b1;
        w_state_next = S_T1;
      end
      S_T1: begin
        run = 1'b1; Zlowout = 1'b1; PCin = 1'b1;
        MDMuxread = 1'b1; RAMread = 1'b1; MDRin = 1'b1;
        w_state_next = w_mem_ready ? S_T2 : S_T1;
      end
      S_T2: begin
        run = 1'b1; MDRout = 1'b1; IRin = 1'b1;
        w_state_next = S_T3;
      end
      S_T3: begin
        run = 1'b1;
        w_state_next = S_T4;
        case (w_class)
          CLS_LOAD, CLS_LOADI, CLS_STORE: begin
            Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
          end
          CLS_ALU_R, CLS_ALU_I: begin
            Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
          end
          CLS_UNARY: begin
            Grb = 1'b1; Rout = 1'b1; Zlowin = 1'b1; w_alu_sel = w_dec_alu;
          end
          CLS_NOP:  w_state_next = S_T0;
          CLS_HALT: w_state_next = S_HALT;
          default: begin
            illegal = 1'b1;
            w_state_next = S_T0;
          end
        endcase
      end
      S_T4: begin
        run = 1'b1;
        w_state_next = S_T5;
        case (w_class)
          CLS_LOAD, CLS_LOADI, CLS_STORE, CLS_ALU_I: begin
            CSEout = 1'b1; Zlowin = 1'b1; w_alu_sel = w_dec_alu;
          end
          CLS_ALU_R: begin
            Grc = 1'b1; Rout = 1'b1; Zlowin = 1'b1; w_alu_sel = w_dec_alu;
          end
          CLS_UNARY: begin
            Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
            w_state_next = S_T0;
          end
          default: w_state_next = S_T0;
        endcase
      end
      S_T5: begin
        run = 1'b1;
        w_state_next = S_T0;
        case (w_class)
          CLS_LOAD, CLS_STORE: begin
            Zlowout = 1'b1; MARin = 1'b1;
            w_state_next = S_T6;
          end
          CLS_LOADI, CLS_ALU_R, CLS_ALU_I: begin
            Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
          end
          default: w_state_next = S_T0;
        endcase
      end
      S_T6: begin
        run = 1'b1;
        w_state_next = S_T0;
        case (w_class)
          CLS_LOAD: begin
            MDMuxread = 1'b1; RAMread = 1'b1; MDRin = 1'b1;
            w_state_next = w_mem_ready ? S_T7 : S_T6;
          end
          CLS_STORE: begin
            Gra = 1'b1; Rout = 1'b1; RAMwrite = 1'b1;
            w_state_next = w_mem_ready ? S_T0 : S_T6;
          end
          default: w_state_next = S_T0;
        endcase
      end
      S_T7: begin
        run = 1'b1; MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        w_state_next = S_T0;
      end
      S_HALT: w_state_next = S_HALT;
      default: w_state_next = S_RESET;
    endcase
  end

endmodule
